// File: rtl/cv32e40p_x_mem_pkg.sv
// Shared types for the CV-X-IF memory responder.
// Optional CV32E40P_X_MEM_MISALIGN_CHECK_EN adds the ERR state.
package cv32e40p_x_mem_pkg;

  localparam int unsigned X_ID_W   = 4;
  localparam int unsigned X_ADDR_W = 32;
  localparam int unsigned X_DATA_W = 32;
  localparam int unsigned X_BE_W   = X_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1
`ifdef CV32E40P_X_MEM_MISALIGN_CHECK_EN
    ,
    ERR  = 2'd2
`endif
  } x_mem_state_e;

  typedef struct packed {
    logic [X_ID_W-1:0]   id;
    logic [X_ADDR_W-1:0] addr;
    logic                we;
    logic [X_BE_W-1:0]   be;
    logic [X_DATA_W-1:0] wdata;
  } x_mem_req_t;

  typedef struct packed {
    logic [X_ID_W-1:0] id;
    logic              we;
  } x_mem_pend_t;

endpackage

// File: rtl/cv32e40p_x_mem_id_fifo.sv
// In-order FIFO of granted transactions awaiting rvalid.
// Push and pop may happen in the same cycle.
module cv32e40p_x_mem_id_fifo
  import cv32e40p_x_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  x_mem_pend_t      pend,
  input  logic             pop,
  output x_mem_pend_t      head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;

  x_mem_pend_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= nxt(wptr_q);
      if (do_pop)  rptr_q <= nxt(rptr_q);
      cnt_q <= cnt_q + CNT_W'(do_push)
                     - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= pend;
  end

endmodule

// File: rtl/cv32e40p_x_mem_responder.sv
// Serves CV-X-IF x_mem requests on the core OBI data port.
// CV32E40P_X_MEM_MISALIGN_CHECK_EN: misaligned requests fail locally.
module cv32e40p_x_mem_responder
  import cv32e40p_x_mem_pkg::*;
#(
  parameter int unsigned ADDR_W          = X_ADDR_W,
  parameter int unsigned DATA_W          = X_DATA_W,
  parameter int unsigned ID_W            = X_ID_W,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                x_mem_valid_i,
  output logic                x_mem_ready_o,
  input  logic [ID_W-1:0]     x_mem_req_id_i,
  input  logic [ADDR_W-1:0]   x_mem_req_addr_i,
  input  logic                x_mem_req_we_i,
  input  logic [DATA_W/8-1:0] x_mem_req_be_i,
  input  logic [DATA_W-1:0]   x_mem_req_wdata_i,
  input  logic                x_mem_req_last_i,
  input  logic                x_mem_req_spec_i,
  output logic                x_mem_result_valid_o,
  output logic [ID_W-1:0]     x_mem_result_id_o,
  output logic [DATA_W-1:0]   x_mem_result_rdata_o,
  output logic                x_mem_result_err_o,
  input  logic                lsu_busy_i,
  output logic                data_req_o,
  input  logic                data_gnt_i,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic                data_we_o,
  output logic [DATA_W/8-1:0] data_be_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  input  logic                data_rvalid_i,
  input  logic [DATA_W-1:0]   data_rdata_i,
  input  logic                data_err_i,
  output logic                idle_o
);

  localparam int unsigned CNT_W =
    $clog2(MAX_OUTSTANDING + 1);

  x_mem_state_e     state_q;
  x_mem_req_t       req_q;
  x_mem_pend_t      head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic             accept;
  logic             gnt_ok;
  logic             pop_ok;
  logic             unused_ok;

  assign x_mem_ready_o = (state_q == IDLE)
    & ~lsu_busy_i
    & (fifo_cnt < CNT_W'(MAX_OUTSTANDING))
    & ~x_mem_req_spec_i;

  assign accept = x_mem_valid_i & x_mem_ready_o;
  assign gnt_ok = (state_q == REQ) & data_gnt_i;
  assign pop_ok = data_rvalid_i & ~fifo_empty;

`ifdef CV32E40P_X_MEM_MISALIGN_CHECK_EN
  logic misalign;
  logic err_done;

  assign misalign =
    ((x_mem_req_be_i == '1)
      && (x_mem_req_addr_i[1:0] != 2'b00))
    || (((x_mem_req_be_i == 4'b0011)
      || (x_mem_req_be_i == 4'b1100))
      && x_mem_req_addr_i[0]);

  // Wait for older results to drain so ids stay in order.
  assign err_done = (state_q == ERR) & fifo_empty;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            req_q.id    <= x_mem_req_id_i;
            req_q.addr  <= x_mem_req_addr_i;
            req_q.we    <= x_mem_req_we_i;
            req_q.be    <= x_mem_req_be_i;
            req_q.wdata <= x_mem_req_we_i
              ? x_mem_req_wdata_i : '0;
`ifdef CV32E40P_X_MEM_MISALIGN_CHECK_EN
            state_q <= misalign ? ERR : REQ;
`else
            state_q <= REQ;
`endif
          end
        end
        REQ: begin
          if (data_gnt_i) state_q <= IDLE;
        end
`ifdef CV32E40P_X_MEM_MISALIGN_CHECK_EN
        ERR: begin
          if (err_done) state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_mem_result_valid_o <= 1'b0;
      x_mem_result_id_o    <= '0;
      x_mem_result_rdata_o <= '0;
      x_mem_result_err_o   <= 1'b0;
    end else begin
      x_mem_result_valid_o <= 1'b0;
      if (pop_ok) begin
        x_mem_result_valid_o <= 1'b1;
        x_mem_result_id_o    <= head.id;
        x_mem_result_rdata_o <= head.we
          ? '0 : data_rdata_i;
        x_mem_result_err_o   <= data_err_i;
      end
`ifdef CV32E40P_X_MEM_MISALIGN_CHECK_EN
      else if (err_done) begin
        x_mem_result_valid_o <= 1'b1;
        x_mem_result_id_o    <= req_q.id;
        x_mem_result_rdata_o <= '0;
        x_mem_result_err_o   <= 1'b1;
      end
`endif
    end
  end

  cv32e40p_x_mem_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (gnt_ok),
    .pend  ('{id: req_q.id, we: req_q.we}),
    .pop   (data_rvalid_i),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign data_req_o   = (state_q == REQ);
  assign data_addr_o  = req_q.addr;
  assign data_we_o    = req_q.we;
  assign data_be_o    = req_q.be;
  assign data_wdata_o = req_q.wdata;
  assign idle_o       = (state_q == IDLE) & fifo_empty;

  assign unused_ok = ^{x_mem_req_last_i, fifo_full};

  // An rvalid with nothing outstanding is dropped.
  a_no_stray_rvalid : assert property (
    @(posedge clk_i) disable iff (rst_i)
    data_rvalid_i |-> !fifo_empty
  );

endmodule

// File: tb/tb_cv32e40p_x_mem_responder.sv
// Directed bench for cv32e40p_x_mem_responder.
// Misalign steps run only with CV32E40P_X_MEM_MISALIGN_CHECK_EN.
module tb_cv32e40p_x_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_mem_valid_i;
  logic        x_mem_ready_o;
  logic [3:0]  x_mem_req_id_i;
  logic [31:0] x_mem_req_addr_i;
  logic        x_mem_req_we_i;
  logic [3:0]  x_mem_req_be_i;
  logic [31:0] x_mem_req_wdata_i;
  logic        x_mem_req_last_i;
  logic        x_mem_req_spec_i;
  logic        x_mem_result_valid_o;
  logic [3:0]  x_mem_result_id_o;
  logic [31:0] x_mem_result_rdata_o;
  logic        x_mem_result_err_o;
  logic        lsu_busy_i;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;
  logic        idle_o;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  cv32e40p_x_mem_responder #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .ID_W            (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .x_mem_valid_i        (x_mem_valid_i),
    .x_mem_ready_o        (x_mem_ready_o),
    .x_mem_req_id_i       (x_mem_req_id_i),
    .x_mem_req_addr_i     (x_mem_req_addr_i),
    .x_mem_req_we_i       (x_mem_req_we_i),
    .x_mem_req_be_i       (x_mem_req_be_i),
    .x_mem_req_wdata_i    (x_mem_req_wdata_i),
    .x_mem_req_last_i     (x_mem_req_last_i),
    .x_mem_req_spec_i     (x_mem_req_spec_i),
    .x_mem_result_valid_o (x_mem_result_valid_o),
    .x_mem_result_id_o    (x_mem_result_id_o),
    .x_mem_result_rdata_o (x_mem_result_rdata_o),
    .x_mem_result_err_o   (x_mem_result_err_o),
    .lsu_busy_i           (lsu_busy_i),
    .data_req_o           (data_req_o),
    .data_gnt_i           (data_gnt_i),
    .data_addr_o          (data_addr_o),
    .data_we_o            (data_we_o),
    .data_be_o            (data_be_o),
    .data_wdata_o         (data_wdata_o),
    .data_rvalid_i        (data_rvalid_i),
    .data_rdata_i         (data_rdata_i),
    .data_err_i           (data_err_i),
    .idle_o               (idle_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    assert (x_mem_req_spec_i == 1'b0)
      else $error("FAIL spec_driven obs=1 exp=0");
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(
    input logic [3:0]  id,
    input logic [31:0] addr,
    input logic        we,
    input logic [3:0]  be,
    input logic [31:0] wd
  );
    x_mem_valid_i     = 1'b1;
    x_mem_req_id_i    = id;
    x_mem_req_addr_i  = addr;
    x_mem_req_we_i    = we;
    x_mem_req_be_i    = be;
    x_mem_req_wdata_i = wd;
  endtask

  task automatic result(
    input string       tag,
    input logic [3:0]  id,
    input logic [31:0] rd,
    input logic        err
  );
    chk({tag, "_valid"}, 64'(x_mem_result_valid_o), 64'd1);
    chk({tag, "_id"}, 64'(x_mem_result_id_o), 64'(id));
    chk({tag, "_rdata"}, 64'(x_mem_result_rdata_o), 64'(rd));
    chk({tag, "_err"}, 64'(x_mem_result_err_o), 64'(err));
  endtask

  initial begin
    rst_i = 1'b1;
    x_mem_valid_i = 1'b0;
    x_mem_req_id_i = '0;
    x_mem_req_addr_i = '0;
    x_mem_req_we_i = 1'b0;
    x_mem_req_be_i = '0;
    x_mem_req_wdata_i = '0;
    x_mem_req_last_i = 1'b1;
    x_mem_req_spec_i = 1'b0;
    lsu_busy_i = 1'b0;
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i = '0;
    data_err_i = 1'b0;
    tick();
    tick();
    chk("rst_idle", 64'(idle_o), 64'd1);
    chk("rst_req", 64'(data_req_o), 64'd0);
    chk("rst_rvalid", 64'(x_mem_result_valid_o), 64'd0);
    chk("rst_addr", 64'(data_addr_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // single load, grant with req, rvalid two cycles on
    drive(4'd3, 32'h100, 1'b0, 4'hF, 32'hAAAA_AAAA);
    #1 chk("ld_ready", 64'(x_mem_ready_o), 64'd1);
    tick();
    x_mem_valid_i = 1'b0;
    data_gnt_i = 1'b1;
    chk("ld_req", 64'(data_req_o), 64'd1);
    chk("ld_addr", 64'(data_addr_o), 64'h100);
    chk("ld_we", 64'(data_we_o), 64'd0);
    chk("ld_wdata", 64'(data_wdata_o), 64'd0);
    tick();
    data_gnt_i = 1'b0;
    chk("ld_req_drop", 64'(data_req_o), 64'd0);
    chk("ld_busy", 64'(idle_o), 64'd0);
    tick();
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hDEAD_BEEF;
    #1 chk("ld_noearly", 64'(x_mem_result_valid_o), 64'd0);
    tick();
    data_rvalid_i = 1'b0;
    result("ld", 4'd3, 32'hDEAD_BEEF, 1'b0);
    tick();
    chk("ld_strobe", 64'(x_mem_result_valid_o), 64'd0);
    chk("ld_idle", 64'(idle_o), 64'd1);

    // store, grant withheld for four cycles
    drive(4'd5, 32'h200, 1'b1, 4'hF, 32'h1234_5678);
    tick();
    x_mem_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st_req", 64'(data_req_o), 64'd1);
      chk("st_addr", 64'(data_addr_o), 64'h200);
      chk("st_wdata", 64'(data_wdata_o), 64'h1234_5678);
      chk("st_we", 64'(data_we_o), 64'd1);
      tick();
    end
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hFFFF_FFFF;
    tick();
    data_rvalid_i = 1'b0;
    result("st", 4'd5, 32'd0, 1'b0);
    tick();

    // three loads against two outstanding slots
    drive(4'd1, 32'h10, 1'b0, 4'hF, 32'd0);
    tick();
    x_mem_req_id_i = 4'd2;
    x_mem_req_addr_i = 32'h14;
    data_gnt_i = 1'b1;
    tick();
    #1 chk("b2b_rdy2", 64'(x_mem_ready_o), 64'd1);
    tick();
    x_mem_req_id_i = 4'd3;
    x_mem_req_addr_i = 32'h18;
    chk("b2b_addr2", 64'(data_addr_o), 64'h14);
    tick();
    data_gnt_i = 1'b0;
    #1 chk("b2b_full", 64'(x_mem_ready_o), 64'd0);
    tick();
    chk("b2b_full2", 64'(x_mem_ready_o), 64'd0);
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hA1;
    tick();
    data_rvalid_i = 1'b0;
    result("b2b_r1", 4'd1, 32'hA1, 1'b0);
    #1 chk("b2b_rdy3", 64'(x_mem_ready_o), 64'd1);
    tick();
    x_mem_valid_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hA2;
    data_err_i = 1'b1;
    tick();
    data_rvalid_i = 1'b0;
    data_err_i = 1'b0;
    result("b2b_r2", 4'd2, 32'hA2, 1'b1);
    chk("b2b_req3", 64'(data_req_o), 64'd1);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hA3;
    tick();
    data_rvalid_i = 1'b0;
    result("b2b_r3", 4'd3, 32'hA3, 1'b0);
    chk("b2b_idle", 64'(idle_o), 64'd1);

    // grant of id 2 in the same cycle as rvalid of id 1
    drive(4'd1, 32'h20, 1'b0, 4'hF, 32'd0);
    tick();
    x_mem_req_id_i = 4'd2;
    x_mem_req_addr_i = 32'h24;
    data_gnt_i = 1'b1;
    tick();
    tick();
    x_mem_valid_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hB1;
    chk("sim_req", 64'(data_req_o), 64'd1);
    tick();
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    result("sim_r1", 4'd1, 32'hB1, 1'b0);
    chk("sim_cnt1", 64'(idle_o), 64'd0);
    tick();
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hB2;
    tick();
    data_rvalid_i = 1'b0;
    result("sim_r2", 4'd2, 32'hB2, 1'b0);
    chk("sim_idle", 64'(idle_o), 64'd1);

    // LSU busy blocks acceptance
    lsu_busy_i = 1'b1;
    drive(4'd9, 32'h300, 1'b0, 4'hF, 32'd0);
    #1 chk("busy_rdy", 64'(x_mem_ready_o), 64'd0);
    tick();
    chk("busy_req", 64'(data_req_o), 64'd0);
    lsu_busy_i = 1'b0;
    #1 chk("busy_rdy2", 64'(x_mem_ready_o), 64'd1);
    tick();
    x_mem_valid_i = 1'b0;
    lsu_busy_i = 1'b1;
    chk("busy_req2", 64'(data_req_o), 64'd1);
    tick();
    chk("busy_hold", 64'(data_req_o), 64'd1);
    lsu_busy_i = 1'b0;

    // reset while in REQ
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rreq_req", 64'(data_req_o), 64'd0);
    chk("rreq_addr", 64'(data_addr_o), 64'd0);
    chk("rreq_be", 64'(data_be_o), 64'd0);
    chk("rreq_idle", 64'(idle_o), 64'd1);
    chk("rreq_res", 64'(x_mem_result_valid_o), 64'd0);
    tick();

`ifdef CV32E40P_X_MEM_MISALIGN_CHECK_EN
    drive(4'd6, 32'h40, 1'b0, 4'hF, 32'd0);
    tick();
    drive(4'd7, 32'h102, 1'b0, 4'hF, 32'd0);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    #1 chk("mis_rdy", 64'(x_mem_ready_o), 64'd1);
    tick();
    x_mem_valid_i = 1'b0;
    chk("mis_noreq", 64'(data_req_o), 64'd0);
    tick();
    chk("mis_noreq2", 64'(data_req_o), 64'd0);
    chk("mis_nores", 64'(x_mem_result_valid_o), 64'd0);
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'h55;
    tick();
    data_rvalid_i = 1'b0;
    result("mis_r6", 4'd6, 32'h55, 1'b0);
    tick();
    result("mis_r7", 4'd7, 32'd0, 1'b1);
    chk("mis_noreq3", 64'(data_req_o), 64'd0);
    tick();
    chk("mis_idle", 64'(idle_o), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
